// File: rtl/bp_update_pkg.sv
// Branch predictor update package.
// Holds the table write bus layout (PHT + BTB halves, 79 bits total), the
// field offsets inside that bus, the PC bits used as PHT index and the
// 2-bit saturating counter encodings plus the counter step helper.
package bp_update_pkg;

  // PC bits that form the PHT index
  localparam int PHT_IDX_BITS = 10;
  localparam int PC_IDX_LSB   = 3;
  localparam int PC_IDX_MSB   = 12;

  // Write bus widths
  localparam int PHT_WBUS_W = 13;
  localparam int BTB_WBUS_W = 66;
  localparam int WBUS_W     = 79;

  // Field offsets within the 79-bit write bus
  localparam int OFF_PHT_WE     = 78;
  localparam int OFF_PHT_IDX    = 68;
  localparam int OFF_PHT_STATE  = 66;
  localparam int OFF_BTB_WE     = 65;
  localparam int OFF_BTB_VALID  = 64;
  localparam int OFF_BTB_PC     = 32;
  localparam int OFF_BTB_TARGET = 0;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } pht_state_e;

  // PHT half of the bus; this is the slice searched for bypass
  typedef struct packed {
    logic                    pht_we;
    logic [PHT_IDX_BITS-1:0] pht_idx;
    logic [1:0]              pht_state;
  } pht_wbus_t;

  // Full write bus, MSB first: {pht_we, pht_idx, pht_state, btb_we,
  // btb_valid, btb_pc, btb_target}
  typedef struct packed {
    logic                    pht_we;
    logic [PHT_IDX_BITS-1:0] pht_idx;
    logic [1:0]              pht_state;
    logic                    btb_we;
    logic                    btb_valid;
    logic [31:0]             btb_pc;
    logic [31:0]             btb_target;
  } bp_wbus_t;

  // One step of a 2-bit saturating counter toward the resolved direction
  function automatic logic [1:0] pht_next(input logic [1:0] s, input logic taken);
    if (taken) return (s == ST) ? s : s + 2'd1;
    return (s == SNT) ? s : s - 2'd1;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Update queue for the branch predictor write side.
// DEPTH-entry synchronous FIFO (DEPTH a power of two, pointers wrap
// naturally). Besides head data and full/empty it exposes the upper TAG_W
// bits of every slot, plus read pointer and occupancy, so the owner can
// search in-flight entries oldest-to-youngest.
// Ports: clk, reset (sync, active high), push/wdata, pop/rdata,
//        full, empty, tags[DEPTH], rd_ptr, count.
module bp_update_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 79,
  parameter int TAG_W = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [W-1:0]                    wdata,
  input  logic                            pop,
  output logic [W-1:0]                    rdata,
  output logic                            full,
  output logic                            empty,
  output logic [DEPTH-1:0][TAG_W-1:0]     tags,
  output logic [$clog2(DEPTH)-1:0]        rd_ptr,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    tags = '0;
    for (int i = 0; i < DEPTH; i++) tags[i] = mem[i][W-1 -: TAG_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy gates every read that matters
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bp_update.sv
// Branch predictor write side.
// Takes resolved branches from execute plus the prediction metadata read at
// fetch, flags mispredictions (registered redirect/mispredict pulse one
// cycle after acceptance) and produces PHT/BTB writes through a QDEPTH-entry
// queue. PHT counters are bypassed from in-flight queue entries and from the
// most recently written PHT entry so back-to-back updates never see stale
// state.
// Ports: clk, reset (sync, active high); ex_* resolved instruction and
//        metadata with ex_valid_i/ex_ready_o handshake; wr_block_i stalls
//        the table write port; bp_wbus_o 79-bit table write bus;
//        redirect_o/redirect_pc_o/mispredict_o to IF.
// Optional: define BP_UPDATE_PERF_EN to add br_cnt_o and mispred_cnt_o
//           (saturating counts of accepted branches and mispredicts).
module bp_update
  import bp_update_pkg::*;
#(
  parameter int QDEPTH    = 2,
  parameter int PHT_IDX_W = PHT_IDX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_is_br_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_bp_valid_i,
  input  logic [1:0]  ex_pht_state_i,
  input  logic        ex_btb_hit_i,
  input  logic [31:0] ex_pred_target_i,
  input  logic        wr_block_i,
  output logic [78:0] bp_wbus_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        mispredict_o
`ifdef BP_UPDATE_PERF_EN
  ,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic                        accept, pred_taken, tgt_mismatch, mispredict;
  logic [PHT_IDX_W-1:0]        idx;
  logic [1:0]                  fetch_state, byp_state;
  bp_wbus_t                    upd, head;
  pht_wbus_t                   cand;
  logic [PW-1:0]               slot;
  logic                        push, pop, q_full, q_empty;
  logic [WBUS_W-1:0]           q_rdata;
  logic [QDEPTH-1:0][PHT_WBUS_W-1:0] q_tags;
  logic [PW-1:0]               q_rd_ptr;
  logic [CW-1:0]               q_count;

  // Most recent PHT write that left the queue
  logic                        lw_valid;
  logic [PHT_IDX_W-1:0]        lw_idx;
  logic [1:0]                  lw_state;

  assign idx        = ex_pc_i[PC_IDX_LSB +: PHT_IDX_W];
  assign ex_ready_o = !q_full;
  assign accept     = ex_valid_i && !q_full;

  // Misprediction decision
  always_comb begin
    pred_taken   = ex_bp_valid_i && ex_pht_state_i[1] && ex_btb_hit_i;
    tgt_mismatch = (ex_target_i != ex_pred_target_i);
    if (ex_is_br_i)
      mispredict = (ex_taken_i != pred_taken) ||
                   (ex_taken_i && pred_taken && tgt_mismatch);
    else
      mispredict = pred_taken;
  end

  // Counter bypass. Priority rises through the code: fetch state, then the
  // last-written register, then queue entries walked oldest to youngest so
  // the youngest match is the one left standing.
  always_comb begin
    fetch_state = ex_bp_valid_i ? ex_pht_state_i : WNT;
    byp_state   = fetch_state;
    if (lw_valid && lw_idx == idx) byp_state = lw_state;
    slot = q_rd_ptr;
    cand = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      slot = q_rd_ptr + PW'(k);
      cand = pht_wbus_t'(q_tags[slot]);
      if (CW'(k) < q_count && cand.pht_we && cand.pht_idx == idx)
        byp_state = cand.pht_state;
    end
  end

  // Build the table update for the offered instruction
  always_comb begin
    upd = '0;
    if (ex_is_br_i) begin
      upd.pht_we    = 1'b1;
      upd.pht_idx   = idx;
      upd.pht_state = pht_next(byp_state, ex_taken_i);
      if (ex_taken_i && (!ex_btb_hit_i || tgt_mismatch)) begin
        upd.btb_we     = 1'b1;
        upd.btb_valid  = 1'b1;
        upd.btb_pc     = ex_pc_i;
        upd.btb_target = ex_target_i;
      end
    end else if (pred_taken) begin
      // Non-branch hit in the BTB: knock the stale entry out
      upd.btb_we = 1'b1;
      upd.btb_pc = ex_pc_i;
    end
  end

  assign push = accept && (upd.pht_we || upd.btb_we);
  // Hold off the write port during reset so queued updates never escape
  assign pop  = !q_empty && !wr_block_i && !reset;
  assign head = bp_wbus_t'(q_rdata);
  assign bp_wbus_o = pop ? q_rdata : '0;

  bp_update_fifo #(
    .DEPTH (QDEPTH),
    .W     (WBUS_W),
    .TAG_W (PHT_WBUS_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  (upd),
    .pop    (pop),
    .rdata  (q_rdata),
    .full   (q_full),
    .empty  (q_empty),
    .tags   (q_tags),
    .rd_ptr (q_rd_ptr),
    .count  (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      mispredict_o  <= 1'b0;
      lw_valid      <= 1'b0;
      lw_idx        <= '0;
      lw_state      <= SNT;
    end else begin
      redirect_o   <= accept && mispredict;
      mispredict_o <= accept && mispredict;
      if (accept && mispredict)
        redirect_pc_o <= (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
      if (pop && head.pht_we) begin
        lw_valid <= 1'b1;
        lw_idx   <= head.pht_idx;
        lw_state <= head.pht_state;
      end
    end
  end

`ifdef BP_UPDATE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (accept && ex_is_br_i && br_cnt_o != 32'hFFFF_FFFF)
        br_cnt_o <= br_cnt_o + 32'd1;
      if (mispredict_o && mispred_cnt_o != 32'hFFFF_FFFF)
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update.sv
module tb_bp_update;
  import bp_update_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i, ex_ready_o, ex_is_br_i, ex_taken_i, ex_bp_valid_i;
  logic        ex_btb_hit_i, wr_block_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
  logic [1:0]  ex_pht_state_i;
  logic [78:0] bp_wbus_o;
  logic        redirect_o, mispredict_o;
  logic [31:0] redirect_pc_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bp_update dut (
    .clk(clk), .reset(reset),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_pc_i(ex_pc_i),
    .ex_is_br_i(ex_is_br_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .ex_bp_valid_i(ex_bp_valid_i), .ex_pht_state_i(ex_pht_state_i),
    .ex_btb_hit_i(ex_btb_hit_i), .ex_pred_target_i(ex_pred_target_i),
    .wr_block_i(wr_block_i), .bp_wbus_o(bp_wbus_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .mispredict_o(mispredict_o)
  );

  // Reference model: update queue as a plain queue, last dequeued PHT write,
  // and the pending redirect.
  bp_wbus_t    mq[$];
  logic        lw_v = 1'b0;
  logic [9:0]  lw_i = '0;
  logic [1:0]  lw_s = '0;
  logic        m_redir = 1'b0;
  logic [31:0] m_rpc = '0;

  task automatic tick();
    bp_wbus_t   e;
    logic       acc, pt, mp;
    logic [9:0] id;
    int         b;
    if (reset) begin
      mq.delete(); lw_v = 0; m_redir = 0; m_rpc = 0;
      return;
    end
    id  = ex_pc_i[12:3];
    acc = ex_valid_i && (mq.size() < 2);
    pt  = ex_bp_valid_i && ex_pht_state_i[1] && ex_btb_hit_i;
    e   = '0;
    mp  = 0;
    if (ex_is_br_i) begin
      mp = (ex_taken_i != pt) || (ex_taken_i && pt && ex_target_i != ex_pred_target_i);
      b  = ex_bp_valid_i ? int'(ex_pht_state_i) : 1;
      if (lw_v && lw_i == id) b = int'(lw_s);
      foreach (mq[k]) if (mq[k].pht_we && mq[k].pht_idx == id) b = int'(mq[k].pht_state);
      e.pht_we    = 1;
      e.pht_idx   = id;
      e.pht_state = 2'(ex_taken_i ? (b < 3 ? b + 1 : 3) : (b > 0 ? b - 1 : 0));
      if (ex_taken_i && (!ex_btb_hit_i || ex_target_i != ex_pred_target_i)) begin
        e.btb_we = 1; e.btb_valid = 1; e.btb_pc = ex_pc_i; e.btb_target = ex_target_i;
      end
    end else if (pt) begin
      mp = 1; e.btb_we = 1; e.btb_pc = ex_pc_i;
    end
    if (mq.size() > 0 && !wr_block_i) begin
      if (mq[0].pht_we) begin lw_v = 1; lw_i = mq[0].pht_idx; lw_s = mq[0].pht_state; end
      void'(mq.pop_front());
    end
    if (acc && (e.pht_we || e.btb_we)) mq.push_back(e);
    m_redir = acc && mp;
    if (acc && mp) m_rpc = (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
  endtask

  task automatic cyc();
    tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic bpv, input logic [1:0] st,
                        input logic hit, input logic [31:0] ptgt, input logic blk);
    ex_valid_i = v; ex_pc_i = pc; ex_is_br_i = br; ex_taken_i = tk; ex_target_i = tgt;
    ex_bp_valid_i = bpv; ex_pht_state_i = st; ex_btb_hit_i = hit;
    ex_pred_target_i = ptgt; wr_block_i = blk;
  endtask

  task automatic set_idle();
    ex_valid_i = 0; wr_block_i = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc();
    reset = 0;
    #1;
    vectors++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ex_ready_o); end
    vectors++; if (bp_wbus_o !== 79'd0) begin errors++; $display("FAIL reset_wbus: got %h want 0", bp_wbus_o); end
    vectors++; if (redirect_o !== 1'b0 || mispredict_o !== 1'b0 || redirect_pc_o !== 32'd0) begin
      errors++; $display("FAIL reset_redirect: got %b/%b/%h want 0/0/0", redirect_o, mispredict_o, redirect_pc_o); end
    cyc();
  endtask

  task automatic test_taken_hit();
    bp_wbus_t w;
    set_in(1, 32'h1C000010, 1, 1, 32'h1C000100, 1, 2'd2, 1, 32'h1C000100, 0);
    #1;
    vectors++; if (bp_wbus_o !== 79'd0) begin errors++; $display("FAIL t1_idle_wbus: got %h want 0", bp_wbus_o); end
    cyc();
    set_idle(); #1;
    w = '0; w.pht_we = 1; w.pht_idx = 10'h002; w.pht_state = 2'd3;
    vectors++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL t1_redirect: got %b want 0", redirect_o); end
    vectors++; if (bp_wbus_o !== w) begin errors++; $display("FAIL t1_wbus: got %h want %h", bp_wbus_o, w); end
    cyc();
  endtask

  task automatic test_not_taken_mispredict();
    bp_wbus_t w;
    set_in(1, 32'h1C000020, 1, 0, 32'h1C000200, 1, 2'd3, 1, 32'h1C000200, 0);
    cyc();
    set_idle(); #1;
    w = '0; w.pht_we = 1; w.pht_idx = 10'h004; w.pht_state = 2'd2;
    vectors++; if (redirect_o !== 1'b1 || mispredict_o !== 1'b1) begin
      errors++; $display("FAIL t2_pulse: got %b/%b want 1/1", redirect_o, mispredict_o); end
    vectors++; if (redirect_pc_o !== 32'h1C000024) begin errors++; $display("FAIL t2_rpc: got %h want 1c000024", redirect_pc_o); end
    vectors++; if (bp_wbus_o !== w) begin errors++; $display("FAIL t2_wbus: got %h want %h", bp_wbus_o, w); end
    cyc();
    vectors++; if (redirect_o !== 1'b0 || mispredict_o !== 1'b0) begin
      errors++; $display("FAIL t2_one_cycle: got %b/%b want 0/0", redirect_o, mispredict_o); end
  endtask

  task automatic test_btb_miss();
    bp_wbus_t w;
    set_in(1, 32'h1C000030, 1, 1, 32'h1C000800, 1, 2'd1, 0, 32'h0, 0);
    cyc();
    set_idle(); #1;
    w = '0; w.pht_we = 1; w.pht_idx = 10'h006; w.pht_state = 2'd2;
    w.btb_we = 1; w.btb_valid = 1; w.btb_pc = 32'h1C000030; w.btb_target = 32'h1C000800;
    vectors++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1C000800) begin
      errors++; $display("FAIL t3_redirect: got %b/%h want 1/1c000800", redirect_o, redirect_pc_o); end
    vectors++; if (bp_wbus_o !== w) begin errors++; $display("FAIL t3_wbus: got %h want %h", bp_wbus_o, w); end
    cyc();
  endtask

  task automatic test_back_to_back();
    bp_wbus_t w;
    logic [1:0] want_st [3] = '{2'd1, 2'd2, 2'd3};
    logic       want_rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    w = '0; w.pht_we = 1; w.pht_idx = 10'h005;
    for (int c = 0; c < 5; c++) begin
      set_in(1, 32'h1C000028, 1, 1, 32'h1C000300, 1, 2'd0, 1, 32'h1C000300, (c < 3) ? 1'b1 : 1'b0);
      #1;
      vectors++; if (ex_ready_o !== want_rdy[c]) begin
        errors++; $display("FAIL t4_ready_c%0d: got %b want %b", c, ex_ready_o, want_rdy[c]); end
      if (c == 2) begin
        vectors++; if (bp_wbus_o !== 79'd0) begin errors++; $display("FAIL t4_blocked: got %h want 0", bp_wbus_o); end
      end
      if (c >= 3) begin
        w.pht_state = want_st[c-3];
        vectors++; if (bp_wbus_o !== w) begin errors++; $display("FAIL t4_wbus_c%0d: got %h want %h", c, bp_wbus_o, w); end
      end
      cyc();
    end
    set_idle(); #1;
    w.pht_state = want_st[2];
    vectors++; if (bp_wbus_o !== w) begin errors++; $display("FAIL t4_wbus_third: got %h want %h", bp_wbus_o, w); end
    cyc();
  endtask

  task automatic test_false_hit();
    bp_wbus_t w;
    set_in(1, 32'h1C000040, 0, 0, 32'h0, 1, 2'd2, 1, 32'h1C000900, 0);
    cyc();
    set_idle(); #1;
    w = '0; w.btb_we = 1; w.btb_valid = 0; w.btb_pc = 32'h1C000040;
    vectors++; if (redirect_o !== 1'b1 || mispredict_o !== 1'b1 || redirect_pc_o !== 32'h1C000044) begin
      errors++; $display("FAIL t5_redirect: got %b/%b/%h want 1/1/1c000044", redirect_o, mispredict_o, redirect_pc_o); end
    vectors++; if (bp_wbus_o !== w) begin errors++; $display("FAIL t5_wbus: got %h want %h", bp_wbus_o, w); end
    cyc();
  endtask

  task automatic test_reset_mid();
    set_in(1, 32'h1C000050, 1, 0, 32'h1C000A00, 1, 2'd3, 1, 32'h1C000A00, 1);
    cyc();
    set_in(1, 32'h1C000058, 1, 0, 32'h1C000A00, 1, 2'd3, 1, 32'h1C000A00, 1);
    #1;
    vectors++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL t6_ready_pre: got %b want 1", ex_ready_o); end
    cyc();
    reset = 1; set_idle(); #1;
    vectors++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL t6_pending: got %b want 1", redirect_o); end
    cyc();
    reset = 0; #1;
    vectors++; if (ex_ready_o !== 1'b1 || bp_wbus_o !== 79'd0) begin
      errors++; $display("FAIL t6_after_reset: ready %b wbus %h want 1/0", ex_ready_o, bp_wbus_o); end
    vectors++; if (redirect_o !== 1'b0 || mispredict_o !== 1'b0 || redirect_pc_o !== 32'd0) begin
      errors++; $display("FAIL t6_redirect: got %b/%b/%h want 0/0/0", redirect_o, mispredict_o, redirect_pc_o); end
    cyc();
    #1;
    vectors++; if (bp_wbus_o !== 79'd0) begin errors++; $display("FAIL t6_stale: got %h want 0", bp_wbus_o); end
    cyc();
  endtask

  task automatic test_random();
    bp_wbus_t   w;
    int         sel;
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      pc  = (sel == 9) ? 32'hFFFF_FFFC
                       : (32'h1C000000 | (32'(sel % 4) << 3) | (32'(sel / 4) << 13));
      set_in(($urandom_range(0, 9) < 8), pc, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             32'h1C001000 + 32'($urandom_range(0, 1)) * 4, ($urandom_range(0, 9) < 8),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h1C001000 + 32'($urandom_range(0, 1)) * 4, ($urandom_range(0, 9) < 3));
      #1;
      w = (mq.size() > 0 && !wr_block_i) ? mq[0] : '0;
      vectors++; if (ex_ready_o !== (mq.size() < 2)) begin
        errors++; $display("FAIL rnd_ready n=%0d: got %b want %b", n, ex_ready_o, mq.size() < 2); end
      vectors++; if (bp_wbus_o !== w) begin
        errors++; $display("FAIL rnd_wbus n=%0d: got %h want %h", n, bp_wbus_o, w); end
      vectors++; if (redirect_o !== m_redir || mispredict_o !== m_redir) begin
        errors++; $display("FAIL rnd_pulse n=%0d: got %b/%b want %b", n, redirect_o, mispredict_o, m_redir); end
      if (m_redir) begin
        vectors++; if (redirect_pc_o !== m_rpc) begin
          errors++; $display("FAIL rnd_rpc n=%0d: got %h want %h", n, redirect_pc_o, m_rpc); end
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_taken_hit();
    test_not_taken_mispredict();
    test_btb_miss();
    test_back_to_back();
    test_false_hit();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bp_update.md
Name: bp_update

Overview:
- Write side of the branch predictor.
- Consumes resolved branch outcomes from the execute stage, together with the prediction metadata that travelled with each instruction from the BP read port.
- Decides mispredictions and drives the IF redirect.
- Produces the PHT and BTB write bus (`is_to_ibus` format) through a 2-entry update queue, with PHT state bypass so back-to-back updates to one index never use stale counters.

Parameters:
- QDEPTH, 2, update queue entries; power of two, >=2.
- PHT_IDX_W, 10, PHT index width; index = pc[12:3].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ex_valid_i  in  1  resolved instruction offered
- ex_ready_o  out  1  update accepted (= queue not full)
- ex_pc_i  in  32  instruction PC
- ex_is_br_i  in  1  instruction is a conditional/direct branch
- ex_taken_i  in  1  actual direction
- ex_target_i  in  32  actual target
- ex_bp_valid_i  in  1  prediction metadata valid
- ex_pht_state_i  in  2  PHT counter read at fetch
- ex_btb_hit_i  in  1  BTB hit at fetch
- ex_pred_target_i  in  32  BTB target at fetch
- wr_block_i  in  1  table write port unavailable this cycle
- bp_wbus_o  out  79  {pht_we, pht_idx[9:0], pht_state[1:0], btb_we, btb_valid, btb_pc[31:0], btb_target[31:0]}
- redirect_o  out  1  one-cycle IF redirect pulse
- redirect_pc_o  out  32  redirect address
- mispredict_o  out  1  one-cycle mispredict pulse (same cycle as redirect_o)

Behaviour:
- Reset: queue empty; bypass register invalid; bp_wbus_o=0; redirect_o=0; redirect_pc_o=0; mispredict_o=0.
- Reset mid-operation discards all queued updates.
- Accept when ex_valid_i && ex_ready_o.
- ex_ready_o = !full. No same-cycle pass-through when full, even if dequeuing.
- pred_taken = ex_bp_valid_i && ex_pht_state_i[1] && ex_btb_hit_i.
- Mispredict cases:
  - branch: ex_taken_i != pred_taken.
  - branch: ex_taken_i && pred_taken && ex_target_i != ex_pred_target_i.
  - non-branch: pred_taken (false BTB hit).
- Redirect/mispredict are registered: asserted exactly 1 cycle after an accepting mispredicted cycle, for 1 cycle.
  - redirect_pc_o = (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i+4, wrapping mod 2^32.
  - Redirect is never blocked by wr_block_i or queue state.
- PHT update, branches only:
  - base = bypassed state; new = taken ? min(base+1,3) : max(base-1,0).
  - Enqueue pht_we=1 even if unchanged.
- Bypass source, first match wins:
  - youngest queue entry with pht_we and equal index;
  - else last-written register (idx/state of the most recent dequeued PHT write, valid after first write);
  - else ex_pht_state_i.
  - If ex_bp_valid_i=0, treat the fetch state as 2'b01 before bypass.
- BTB update:
  - Taken branch with (!ex_btb_hit_i || target mismatch): btb_we=1, btb_valid=1, pc, ex_target_i.
  - Non-branch false hit: btb_we=1, btb_valid=0 (invalidate).
  - Otherwise btb_we=0.
- Enqueue only if pht_we || btb_we. Accepted non-branches with no BTB action are dropped, but still ack'd.
- Dequeue: head drives bp_wbus_o for one cycle when queue non-empty && !wr_block_i; otherwise bp_wbus_o=0.
  - Minimum latency accept -> table write is 1 cycle.
  - Order is preserved.
- Simultaneous enqueue+dequeue when not full: count unchanged; bypass sees the entry being dequeued via the last-written register in the following cycle.
- Pointers wrap mod QDEPTH.

Optional Feature:
- Macro BP_UPDATE_PERF_EN.
- When defined, adds outputs br_cnt_o[31:0] and mispred_cnt_o[31:0]:
  - counts accepted branches and asserted mispredicts;
  - saturate at 32'hFFFF_FFFF;
  - reset to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Bp_Define.vh gains:
  - PhtWbusWidth=13, BtbWbusWidth=66, IStoBPWbusWidth=79;
  - field offsets;
  - PHT index range [12:3];
  - counter encodings SNT=0, WNT=1, WT=2, ST=3.
- One sub-module, bp_update_fifo: a QDEPTH-entry synchronous FIFO with full/empty, exposing entries for the bypass search.
- Decide, saturate and redirect logic stay in bp_update.

Test Plan:
- Taken branch, pc=0x1C000010, bp_valid=1, state=2, hit=1, pred_target=target=0x1C000100 -> no redirect; next cycle bp_wbus_o pht_we=1, idx=0x002, state=3, btb_we=0.
- Not-taken branch predicted taken (state=3, hit=1), pc=0x1C000020 -> cycle+1 redirect_o=1, redirect_pc_o=0x1C000024, mispredict_o=1; PHT writes state=2.
- Taken branch, btb_hit=0, state=1, target 0x1C000800 -> redirect to 0x1C000800; write pht state=2, btb_we=1 valid=1 target=0x1C000800.
- Three taken updates to idx 0x005 on consecutive cycles, each with stale ex_pht_state_i=0, wr_block_i held 1 -> queue fills; ex_ready_o drops after 2 accepts; on release writes are state 1 then 2, and third accepted afterwards writes 3.
- Non-branch with btb_hit=1, state=2 -> redirect pc+4; btb_we=1, btb_valid=0.
- Reset asserted with 2 queued entries and a pending redirect -> next cycle all outputs 0, ex_ready_o=1, no stale write emitted.
